// File: rtl/add4_seq_ctrl_if.sv
// Requester-side bus of the nibble-serial adder sequencer: operands and
// start request in, busy/done status and the registered result out.
`timescale 1ns/1ps
interface add4_seq_ctrl_if #(
  parameter int NIBBLES = 4
);
  localparam int W = 4 * NIBBLES;

  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;

  modport master (
    output start, a, b, cin,
    input  busy, done, sum, cout
  );

  modport slave (
    input  start, a, b, cin,
    output busy, done, sum, cout
  );
endinterface

// File: rtl/add4_seq_ctrl.sv
// Nibble-serial wide adder sequencer. Operands are latched on an accepted
// start, then pushed through an external 4-bit adder LSB nibble first with
// the adder's carry-out fed back as the next carry-in. The finished result
// is published on sum/cout together with a one-cycle done pulse.
`timescale 1ns/1ps
module add4_seq_ctrl #(
  parameter int NIBBLES = 4
) (
  input  logic                clk,
  input  logic                rst,
  add4_seq_ctrl_if.slave      req,
  output logic [3:0]          add_a,
  output logic [3:0]          add_b,
  output logic                add_ci,
  input  logic [3:0]          add_sum,
  input  logic                add_co
);
  localparam int W  = 4 * NIBBLES;
  localparam int CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(NIBBLES - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q,   cnt_d;
  logic          carry_q, carry_d;
  logic [W-1:0]  a_q,     a_d;
  logic [W-1:0]  b_q,     b_d;
  logic [W-1:0]  acc_q,   acc_d;
  logic [W-1:0]  sum_q,   sum_d;
  logic          cout_q,  cout_d;
  logic          busy_q,  busy_d;
  logic          done_q,  done_d;

  // Next-state logic: accept in IDLE, one nibble per RUN cycle, publish on DONE entry.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    unique case (state_q)
      IDLE: begin
        if (req.start) begin
          a_d     = req.a;
          b_d     = req.b;
          carry_d = req.cin;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        acc_d[{cnt_q, 2'b00} +: 4] = add_sum;
        carry_d = add_co;
        if (cnt_q == LAST) begin
          sum_d   = acc_d;
          cout_d  = add_co;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    // Status flags are registered copies of the state being entered.
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  // State and datapath registers; reset abandons any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Adder drive comes from registers only so no start/operand input reaches add_*.
  always_comb begin
    add_a  = 4'h0;
    add_b  = 4'h0;
    add_ci = 1'b0;
    if (state_q == RUN) begin
      add_a  = a_q[{cnt_q, 2'b00} +: 4];
      add_b  = b_q[{cnt_q, 2'b00} +: 4];
      add_ci = carry_q;
    end
  end

  assign req.busy = busy_q;
  assign req.done = done_q;
  assign req.sum  = sum_q;
  assign req.cout = cout_q;
endmodule
